// File: rtl/potential_adder_pkg.sv
// Shared neuron definitions: accumulator FSM encoding and FP32 constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package potential_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even.
// Latency: 0 cycles (pure combinational); denormal inputs/results flush to zero.
// Backpressure: none; exception flags Inf/NaN operands and overflow to infinity.
module Addition_Subtraction
    import potential_adder_pkg::*;
(
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        operation,
    output logic [31:0] result,
    output logic        exception
);

    logic              sa, sb, s_big, eff_sub, special;
    logic [7:0]        ea, eb, e_big, e_small, diff;
    logic [23:0]       ma, mb, m_big, m_small;
    logic [26:0]       big_x, small_x, shifted, norm;
    logic              align_sticky, round_up;
    logic [27:0]       sum;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_w;

    // Align, add/subtract, normalise and round in a single combinational pass
    always_comb begin
        result       = FP32_ZERO;
        exception    = 1'b0;
        sa           = a_operand[31];
        sb           = b_operand[31] ^ operation;
        ea           = a_operand[30:23];
        eb           = b_operand[30:23];
        ma           = (ea == 8'd0) ? 24'd0 : {1'b1, a_operand[22:0]};
        mb           = (eb == 8'd0) ? 24'd0 : {1'b1, b_operand[22:0]};
        special      = (ea == FP32_EXP_MAX) || (eb == FP32_EXP_MAX);
        eff_sub      = sa ^ sb;

        // Larger magnitude drives the result sign and exponent
        if (a_operand[30:0] >= b_operand[30:0]) begin
            s_big = sa; e_big = ea; m_big = ma; e_small = eb; m_small = mb;
        end else begin
            s_big = sb; e_big = eb; m_big = mb; e_small = ea; m_small = ma;
        end

        diff         = e_big - e_small;
        big_x        = {m_big, 3'b000};
        small_x      = {m_small, 3'b000};
        align_sticky = 1'b0;
        if (diff >= 8'd27) begin
            shifted      = 27'd0;
            align_sticky = |m_small;
        end else begin
            shifted = small_x >> diff;
            for (int i = 0; i < 27; i++) begin
                if (i < int'(diff)) align_sticky = align_sticky | small_x[i];
            end
        end
        shifted[0] = shifted[0] | align_sticky;

        sum   = eff_sub ? ({1'b0, big_x} - {1'b0, shifted})
                        : ({1'b0, big_x} + {1'b0, shifted});
        exp_w = $signed({2'b00, e_big});
        norm  = sum[26:0];

        // Carry out shifts right once; cancellation shifts left to the leading one
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_w = exp_w + 10'sd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!norm[26]) begin
                    norm  = {norm[25:0], 1'b0};
                    exp_w = exp_w - 10'sd1;
                end
            end
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            mant_r = mant_r >> 1;
            exp_w  = exp_w + 10'sd1;
        end

        if (special) begin
            exception = 1'b1;
            result    = FP32_QNAN;
        end else if (sum == 28'd0) begin
            result = FP32_ZERO;
        end else if (exp_w >= 10'sd255) begin
            exception = 1'b1;
            result    = {s_big, FP32_EXP_MAX, 23'd0};
        end else if (exp_w <= 10'sd0) begin
            result = {s_big, 31'd0};
        end else begin
            result = {s_big, exp_w[7:0], mant_r[22:0]};
        end
    end

endmodule

// File: rtl/potential_adder.sv
// Membrane potential accumulator: sums up to MAX_FANIN FP32 weights onto the decayed potential.
// Latency: one weight per cycle; potential_valid pulses one cycle after the edge sampling timestep_end.
// Backpressure: weight_ready drops in the cycle after count hits MAX_FANIN; excess offers set fanin_overflow.
module potential_adder
    import potential_adder_pkg::*;
#(
    parameter int MAX_FANIN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timestep_start,
    input  logic [31:0] decayed_potential,
    input  logic        weight_valid,
    input  logic [31:0] weight,
    output logic        weight_ready,
    input  logic        timestep_end,
    output logic [31:0] new_potential,
    output logic        potential_valid,
    output logic        fanin_overflow,
    output logic        add_exception
);

    localparam int CW = $clog2(MAX_FANIN + 1);

    state_t        state, state_nxt;
    logic [31:0]   acc, sum;
    logic [CW-1:0] count;
    logic          add_exc, handshake, at_limit;

    assign at_limit  = (count >= CW'(MAX_FANIN));
    assign handshake = weight_valid & weight_ready;

    // The adder sits directly between acc and its D input for single-cycle accumulation
    Addition_Subtraction u_add (
        .a_operand (acc),
        .b_operand (weight),
        .operation (1'b0),
        .result    (sum),
        .exception (add_exc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: start has priority over end while accumulating
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (timestep_start) state_nxt = ACCUM;
            ACCUM:   if (timestep_start) state_nxt = ACCUM;
                     else if (timestep_end) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: accept weights only while accumulating below the fan-in cap
    always_comb begin
        weight_ready = (state == ACCUM) && !at_limit;
    end

    // Accumulator, fan-in counter, sticky flags and the registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc             <= FP32_ZERO;
            count           <= '0;
            new_potential   <= FP32_ZERO;
            potential_valid <= 1'b0;
            fanin_overflow  <= 1'b0;
            add_exception   <= 1'b0;
        end else begin
            potential_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (timestep_start) begin
                        acc            <= decayed_potential;
                        count          <= '0;
                        fanin_overflow <= 1'b0;
                        add_exception  <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (timestep_start) begin
                        acc            <= decayed_potential;
                        count          <= '0;
                        fanin_overflow <= 1'b0;
                        add_exception  <= 1'b0;
                    end else begin
                        if (handshake) begin
                            count <= count + CW'(1);
                            if (add_exc) add_exception <= 1'b1;
                            else         acc           <= sum;
                        end
                        if (weight_valid && at_limit) fanin_overflow <= 1'b1;
                    end
                end
                OUT: begin
                    new_potential   <= acc;
                    potential_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_potential_adder.sv
// Directed bench for potential_adder: hand-computed FP32 results, timing and flag checks.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises the fan-in cap with weight_valid held high past MAX_FANIN.
module tb_potential_adder;
    import potential_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        timestep_start;
    logic [31:0] decayed_potential;
    logic        weight_valid;
    logic [31:0] weight;
    logic        weight_ready;
    logic        timestep_end;
    logic [31:0] new_potential;
    logic        potential_valid;
    logic        fanin_overflow;
    logic        add_exception;

    int total = 0;
    int bad   = 0;
    int vcount;

    potential_adder #(.MAX_FANIN(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .timestep_start    (timestep_start),
        .decayed_potential (decayed_potential),
        .weight_valid      (weight_valid),
        .weight            (weight),
        .weight_ready      (weight_ready),
        .timestep_end      (timestep_end),
        .new_potential     (new_potential),
        .potential_valid   (potential_valid),
        .fanin_overflow    (fanin_overflow),
        .add_exception     (add_exception)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        timestep_start    = 1'b0;
        timestep_end      = 1'b0;
        decayed_potential = FP32_ZERO;
        weight_valid      = 1'b0;
        weight            = FP32_ZERO;
        #1;
        check("rst_np",    new_potential,   32'h0);
        check("rst_pv",    {31'd0, potential_valid}, 32'd0);
        check("rst_wr",    {31'd0, weight_ready},    32'd0);
        check("rst_ovf",   {31'd0, fanin_overflow},  32'd0);
        check("rst_exc",   {31'd0, add_exception},   32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // end while idle is ignored
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        tick();
        check("idle_end_pv", {31'd0, potential_valid}, 32'd0);
        check("idle_end_wr", {31'd0, weight_ready},    32'd0);

        // 2.0 + 1 + 1 + 1 = 5.0
        timestep_start = 1'b1; decayed_potential = 32'h4000_0000;
        tick();
        timestep_start = 1'b0;
        check("t1_wr", {31'd0, weight_ready}, 32'd1);
        weight_valid = 1'b1; weight = FP32_ONE;
        tick(); tick(); tick();
        weight_valid = 1'b0; timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        check("t1_pv_early", {31'd0, potential_valid}, 32'd0);
        tick();
        check("t1_pv",  {31'd0, potential_valid}, 32'd1);
        check("t1_np",  new_potential, 32'h40A0_0000);
        tick();
        check("t1_pv_once", {31'd0, potential_valid}, 32'd0);
        check("t1_np_hold", new_potential, 32'h40A0_0000);

        // 2.0 + (-2.0) = +0.0, no exception
        timestep_start = 1'b1; decayed_potential = 32'h4000_0000;
        tick();
        timestep_start = 1'b0;
        weight_valid = 1'b1; weight = 32'hC000_0000;
        tick();
        weight_valid = 1'b0; timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        tick();
        check("t2_pv",  {31'd0, potential_valid}, 32'd1);
        check("t2_np",  new_potential, 32'h0000_0000);
        check("t2_exc", {31'd0, add_exception}, 32'd0);

        // fan-in cap: 17 offers of 1.0 on 0.0, only 16 accepted
        timestep_start = 1'b1; decayed_potential = FP32_ZERO;
        tick();
        timestep_start = 1'b0;
        weight_valid = 1'b1; weight = FP32_ONE;
        for (int i = 0; i < 16; i++) tick();
        check("t3_wr_low", {31'd0, weight_ready}, 32'd0);
        tick();
        check("t3_ovf", {31'd0, fanin_overflow}, 32'd1);
        weight_valid = 1'b0; timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        tick();
        check("t3_pv",  {31'd0, potential_valid}, 32'd1);
        check("t3_np",  new_potential, 32'h4180_0000);
        check("t3_exc", {31'd0, add_exception}, 32'd0);

        // weight handshaken on the same cycle as end is included
        timestep_start = 1'b1; decayed_potential = FP32_ONE;
        tick();
        timestep_start = 1'b0;
        check("t4_ovf_clr", {31'd0, fanin_overflow}, 32'd0);
        weight_valid = 1'b1; weight = FP32_ONE; timestep_end = 1'b1;
        tick();
        weight_valid = 1'b0; timestep_end = 1'b0;
        tick();
        check("t4_pv", {31'd0, potential_valid}, 32'd1);
        check("t4_np", new_potential, 32'h4000_0000);

        // reset mid-timestep discards the partial sum
        timestep_start = 1'b1; decayed_potential = 32'h4000_0000;
        tick();
        timestep_start = 1'b0;
        weight_valid = 1'b1; weight = FP32_ONE;
        tick(); tick();
        weight_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_np", new_potential, 32'h0);
        check("t5_rst_wr", {31'd0, weight_ready}, 32'd0);
        check("t5_rst_pv", {31'd0, potential_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vcount += int'(potential_valid);
        end
        check("t5_no_pv", vcount, 32'd0);
        check("t5_wr_idle", {31'd0, weight_ready}, 32'd0);
        timestep_start = 1'b1; decayed_potential = 32'h41DE_B852;
        tick();
        timestep_start = 1'b0; timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        tick();
        check("t5_pv", {31'd0, potential_valid}, 32'd1);
        check("t5_np", new_potential, 32'h41DE_B852);

        // restart mid-accumulation: partial sum dropped, single output
        timestep_start = 1'b1; decayed_potential = 32'h4000_0000;
        tick();
        timestep_start = 1'b0;
        weight_valid = 1'b1; weight = FP32_ONE;
        tick();
        weight_valid = 1'b0;
        timestep_start = 1'b1; decayed_potential = 32'h4040_0000;
        vcount = 0;
        tick();
        vcount += int'(potential_valid);
        timestep_start = 1'b0; timestep_end = 1'b1;
        tick();
        vcount += int'(potential_valid);
        timestep_end = 1'b0;
        tick();
        vcount += int'(potential_valid);
        check("t6_np", new_potential, 32'h4040_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            vcount += int'(potential_valid);
        end
        check("t6_pv_count", vcount, 32'd1);

        // start and end together: start wins, no output
        timestep_start = 1'b1; decayed_potential = FP32_ONE;
        tick();
        timestep_start = 1'b0;
        weight_valid = 1'b1; weight = FP32_ONE;
        tick();
        weight_valid = 1'b0;
        timestep_start = 1'b1; timestep_end = 1'b1; decayed_potential = 32'h4040_0000;
        tick();
        timestep_start = 1'b0; timestep_end = 1'b0;
        tick();
        check("t7_no_pv", {31'd0, potential_valid}, 32'd0);
        check("t7_wr",    {31'd0, weight_ready},    32'd1);
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        tick();
        check("t7_np", new_potential, 32'h4040_0000);

        // infinite weight: acc holds, flag sets, count still advances; start in OUT ignored
        timestep_start = 1'b1; decayed_potential = FP32_ONE;
        tick();
        timestep_start = 1'b0;
        weight_valid = 1'b1; weight = 32'h7F80_0000;
        tick();
        check("t8_exc", {31'd0, add_exception}, 32'd1);
        weight = FP32_ONE;
        tick();
        weight_valid = 1'b0; timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        timestep_start = 1'b1; decayed_potential = 32'h4040_0000;
        tick();
        timestep_start = 1'b0;
        check("t8_pv",  {31'd0, potential_valid}, 32'd1);
        check("t8_np",  new_potential, 32'h4000_0000);
        check("t8_wr_idle", {31'd0, weight_ready}, 32'd0);
        tick();
        check("t8_still_idle", {31'd0, weight_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/potential_adder.md
POTENTIAL_ADDER -- requirements
Module: potential_adder

Interface
REQ-001 SHALL have parameter MAX_FANIN, default 16: maximum weights accepted per timestep.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port timestep_start  input  1: one-cycle pulse; loads decayed_potential and opens a timestep.
REQ-005 SHALL have port decayed_potential  input  32: IEEE-754 single-precision membrane potential from the decay stage.
REQ-006 SHALL have port weight_valid  input  1: weight offered.
REQ-007 SHALL have port weight  input  32: IEEE-754 single-precision synaptic weight.
REQ-008 SHALL have port weight_ready  output  1: weight can be accepted this cycle.
REQ-009 SHALL have port timestep_end  input  1: one-cycle pulse; closes the timestep.
REQ-010 SHALL have port new_potential  output  32: accumulated potential, fed to the decay stage.
REQ-011 SHALL have port potential_valid  output  1: one-cycle pulse qualifying new_potential.
REQ-012 SHALL have port fanin_overflow  output  1: sticky; MAX_FANIN was reached this timestep.
REQ-013 SHALL have port add_exception  output  1: sticky; an addition raised an exception this timestep.

Function
REQ-014 SHALL implement states IDLE, ACCUM and OUT.
REQ-015 IDLE: weight_ready=0; timestep_start loads acc=decayed_potential, count=0, clears both sticky flags, and moves to ACCUM.
REQ-016 ACCUM: weight_ready=1 while count<MAX_FANIN; a handshake (weight_valid & weight_ready) SHALL register acc=acc+weight and count=count+1 in the same edge.
REQ-017 Accumulation SHALL sustain one weight per cycle, with the adder in the combinational path to the acc register.
REQ-018 When count reaches MAX_FANIN, weight_ready SHALL drop the following cycle and fanin_overflow SHALL set if weight_valid is still high.
REQ-019 If the adder exception flag is high on a handshake, acc SHALL hold its prior value, add_exception SHALL set, and count SHALL still increment.
REQ-020 timestep_end in ACCUM moves to OUT; a weight handshaken in the same cycle SHALL be included in the result.
REQ-021 timestep_start in ACCUM restarts: reload acc, clear count and flags, discard the partial sum, emit no output.
REQ-022 If timestep_start and timestep_end are both high in ACCUM, start SHALL take priority.
REQ-023 OUT: new_potential=acc and potential_valid=1 for exactly one cycle, then move to IDLE; timestep_start in OUT is ignored.
REQ-024 Latency: potential_valid SHALL assert exactly one cycle after the timestep_end edge.
REQ-025 new_potential SHALL hold its last value until the next OUT.
REQ-026 timestep_end in IDLE SHALL be ignored.
REQ-027 count width SHALL be clog2(MAX_FANIN+1).

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, acc=0, count=0, new_potential=0, potential_valid=0, weight_ready=0, fanin_overflow=0, add_exception=0.
REQ-029 Reset mid-timestep SHALL discard the partial sum and emit no potential_valid.
REQ-030 After rst_n rises, no action SHALL occur until the next timestep_start.

Structure
REQ-031 State encoding and FP32 constants (0.0, +1.0) SHALL live in the shared neuron package.
REQ-032 SHALL instantiate exactly one Addition_Subtraction sub-module in add mode (operation bit 0), using its exception output.

Verification
REQ-033 Start, decayed_potential=0x40000000, then three weights 0x3F800000 and end -> new_potential=0x40A00000, single-cycle valid, one cycle after end.
REQ-034 Start, decayed_potential=0x40000000, weight 0xC0000000, end -> new_potential=0x00000000, add_exception=0.
REQ-035 MAX_FANIN=16, decayed_potential=0, 17 consecutive weights 0x3F800000 -> weight_ready low after the 16th, fanin_overflow=1, new_potential=0x41800000.
REQ-036 Weight 0x3F800000 handshaken in the same cycle as timestep_end on decayed_potential 0x3F800000 -> new_potential=0x40000000.
REQ-037 rst_n pulsed low after two weights -> all outputs 0, no potential_valid; next start with 0x41DEB852 and immediate end -> new_potential=0x41DEB852.
REQ-038 Second timestep_start mid-ACCUM with decayed_potential 0x40400000, then end -> new_potential=0x40400000, a single potential_valid.
